// File: rtl/cpu_pkg.sv
// Shared ISA definitions for the 19-bit CPU: opcodes, instruction field positions,
// controller state encoding and small opcode-class helpers.
package cpu_pkg;

  localparam int DATA_W  = 8;
  localparam int INSTR_W = 19;
  localparam int OP_W    = 5;

  localparam logic [OP_W-1:0] OP_NOP  = 5'd0;
  localparam logic [OP_W-1:0] OP_ADD  = 5'd1;
  localparam logic [OP_W-1:0] OP_SUB  = 5'd2;
  localparam logic [OP_W-1:0] OP_AND  = 5'd3;
  localparam logic [OP_W-1:0] OP_OR   = 5'd4;
  localparam logic [OP_W-1:0] OP_XOR  = 5'd5;
  localparam logic [OP_W-1:0] OP_NOT  = 5'd6;
  localparam logic [OP_W-1:0] OP_LDI  = 5'd7;
  localparam logic [OP_W-1:0] OP_MOV  = 5'd8;
  localparam logic [OP_W-1:0] OP_JMP  = 5'd9;
  localparam logic [OP_W-1:0] OP_BEQ  = 5'd10;
  localparam logic [OP_W-1:0] OP_HALT = 5'd11;

  localparam int OP_HI  = 18;
  localparam int OP_LO  = 14;
  localparam int RD_HI  = 13;
  localparam int RD_LO  = 12;
  localparam int RS1_HI = 11;
  localparam int RS1_LO = 10;
  localparam int RS2_HI = 9;
  localparam int RS2_LO = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  // ADD..MOV form one contiguous block: they write rd and update ZF
  function automatic logic op_writes(input logic [OP_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_MOV);
  endfunction

  function automatic logic op_sets_cf(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/cpu_alu8.sv
// Combinational 8-bit ALU; carry is the ADD carry-out or the SUB borrow.
module cpu_alu8
  import cpu_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // the extra top bit of the widened difference is set exactly when a < b
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_SUB: begin
        result = diff[DATA_W-1:0];
        carry  = diff[DATA_W];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_LDI:  result = imm;
      OP_MOV:  result = a;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/cpu_fetch_exec_ctrl.sv
// Five-cycle fetch/wait/decode/exec/writeback controller driving the 4x8 register
// file; handles JMP/BEQ/HALT and keeps the ZF/CF flag registers.
module cpu_fetch_exec_ctrl #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = cpu_pkg::INSTR_W,
  parameter int DATA_W  = cpu_pkg::DATA_W
) (
  input  logic               CLK,
  input  logic               RST,
  output logic [PC_W-1:0]    ROM_ADDR,
  input  logic [INSTR_W-1:0] ROM_DATA,
  output logic [1:0]         RA_SEL,
  output logic [1:0]         RB_SEL,
  input  logic [DATA_W-1:0]  RA_DATA,
  input  logic [DATA_W-1:0]  RB_DATA,
  output logic               WB_EN,
  output logic [1:0]         WB_SEL,
  output logic [DATA_W-1:0]  WB_DATA,
  output logic               ZF,
  output logic               CF,
  output logic               HALTED
);

  import cpu_pkg::*;

  state_t state_reg, state_next;

  logic [PC_W-1:0]    pc_reg, pc_next;
  logic [INSTR_W-1:0] ir_reg, ir_next;
  logic [DATA_W-1:0]  result_reg, result_next;
  logic               taken_reg, taken_next;
  logic               zf_reg, zf_next;
  logic               cf_reg, cf_next;
  logic               wb_en_reg, wb_en_next;
  logic [1:0]         wb_sel_reg, wb_sel_next;
  logic [DATA_W-1:0]  wb_data_reg, wb_data_next;
  logic               halted_reg, halted_next;

  logic [OP_W-1:0]   op;
  logic [1:0]        rd;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_zero;

  assign op  = ir_reg[OP_HI:OP_LO];
  assign rd  = ir_reg[RD_HI:RD_LO];
  assign imm = ir_reg[IMM_HI:IMM_LO];

  cpu_alu8 u_alu (
    .op     (op),
    .a      (RA_DATA),
    .b      (RB_DATA),
    .imm    (imm),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_reg <= S_FETCH;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:  state_next = S_WAIT;
      S_WAIT:   state_next = S_DECODE;
      S_DECODE: state_next = S_EXEC;
      S_EXEC:   state_next = S_WB;
      S_WB:     state_next = (op == OP_HALT) ? S_HALT : S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
  end

  always_comb begin
    pc_next      = pc_reg;
    ir_next      = ir_reg;
    result_next  = result_reg;
    taken_next   = taken_reg;
    zf_next      = zf_reg;
    cf_next      = cf_reg;
    wb_en_next   = 1'b0;
    wb_sel_next  = wb_sel_reg;
    wb_data_next = wb_data_reg;
    halted_next  = halted_reg;
    case (state_reg)
      S_DECODE: ir_next = ROM_DATA;
      S_EXEC: begin
        // operands are sampled here, a full cycle before writeback, so rd may alias rs1/rs2
        result_next = alu_result;
        taken_next  = (op == OP_JMP) || ((op == OP_BEQ) && (RA_DATA == RB_DATA));
        if (op_writes(op))  zf_next = alu_zero;
        if (op_sets_cf(op)) cf_next = alu_carry;
      end
      S_WB: begin
        if (op == OP_HALT) begin
          halted_next = 1'b1;
        end else begin
          // imm8 is truncated or zero-extended to the PC width; PC+1 wraps naturally
          pc_next = taken_reg ? PC_W'(imm) : pc_reg + PC_W'(1);
          if (op_writes(op)) begin
            wb_en_next   = 1'b1;
            wb_sel_next  = rd;
            wb_data_next = result_reg;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_reg      <= '0;
      ir_reg      <= '0;
      result_reg  <= '0;
      taken_reg   <= 1'b0;
      zf_reg      <= 1'b0;
      cf_reg      <= 1'b0;
      wb_en_reg   <= 1'b0;
      wb_sel_reg  <= '0;
      wb_data_reg <= '0;
      halted_reg  <= 1'b0;
    end else begin
      pc_reg      <= pc_next;
      ir_reg      <= ir_next;
      result_reg  <= result_next;
      taken_reg   <= taken_next;
      zf_reg      <= zf_next;
      cf_reg      <= cf_next;
      wb_en_reg   <= wb_en_next;
      wb_sel_reg  <= wb_sel_next;
      wb_data_reg <= wb_data_next;
      halted_reg  <= halted_next;
    end
  end

  assign ROM_ADDR = pc_reg;
  assign RA_SEL   = ir_reg[RS1_HI:RS1_LO];
  assign RB_SEL   = ir_reg[RS2_HI:RS2_LO];
  assign WB_EN    = wb_en_reg;
  assign WB_SEL   = wb_sel_reg;
  assign WB_DATA  = wb_data_reg;
  assign ZF       = zf_reg;
  assign CF       = cf_reg;
  assign HALTED   = halted_reg;

endmodule

// File: tb/tb_cpu_fetch_exec_ctrl.sv
// Directed bench for cpu_fetch_exec_ctrl with a synchronous ROM and a 4x8 register-file model.
module tb_cpu_fetch_exec_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  ROM_ADDR;
  logic [18:0] ROM_DATA;
  logic [1:0]  RA_SEL, RB_SEL;
  logic [7:0]  RA_DATA, RB_DATA;
  logic        WB_EN;
  logic [1:0]  WB_SEL;
  logic [7:0]  WB_DATA;
  logic        ZF, CF, HALTED;

  logic [18:0] rom [256];
  logic [7:0]  regs [4] = '{default: 8'h00};

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  cpu_fetch_exec_ctrl #(.PC_W(8), .INSTR_W(19), .DATA_W(8)) dut (
    .CLK(CLK), .RST(RST), .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA),
    .RA_SEL(RA_SEL), .RB_SEL(RB_SEL), .RA_DATA(RA_DATA), .RB_DATA(RB_DATA),
    .WB_EN(WB_EN), .WB_SEL(WB_SEL), .WB_DATA(WB_DATA),
    .ZF(ZF), .CF(CF), .HALTED(HALTED)
  );

  always @(posedge CLK) ROM_DATA <= rom[ROM_ADDR];
  always @(posedge CLK) if (WB_EN) regs[WB_SEL] <= WB_DATA;
  assign RA_DATA = regs[RA_SEL];
  assign RB_DATA = regs[RB_SEL];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic [18:0] enc(input int op, input int rd, input int rs1,
                                      input int rs2, input int imm);
    return {op[4:0], rd[1:0], rs1[1:0], rs2[1:0], imm[7:0]};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 19'd0;
  endtask

  // leaves the bench at the falling edge of cycle 0 (first FETCH)
  task automatic apply_reset();
    @(negedge CLK) RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK) RST = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check_wb(input string tag, input int sel, input int data);
    check({tag, "_wb_en"}, 32'(WB_EN), 32'd1);
    check({tag, "_wb_sel"}, 32'(WB_SEL), 32'(sel));
    check({tag, "_wb_data"}, 32'(WB_DATA), 32'(data));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rom_addr"}, 32'(ROM_ADDR), 32'd0);
    check({tag, "_wb_en"}, 32'(WB_EN), 32'd0);
    check({tag, "_wb_sel"}, 32'(WB_SEL), 32'd0);
    check({tag, "_wb_data"}, 32'(WB_DATA), 32'd0);
    check({tag, "_ra_sel"}, 32'(RA_SEL), 32'd0);
    check({tag, "_rb_sel"}, 32'(RB_SEL), 32'd0);
    check({tag, "_zf"}, 32'(ZF), 32'd0);
    check({tag, "_cf"}, 32'(CF), 32'd0);
    check({tag, "_halted"}, 32'(HALTED), 32'd0);
  endtask

  initial begin
    int wb_count;

    // 1: basic LDI/ADD/HALT with exact cycle timing
    clear_rom();
    rom[0] = enc(7, 1, 0, 0, 8'h05);
    rom[1] = enc(7, 2, 0, 0, 8'h03);
    rom[2] = enc(1, 3, 1, 2, 0);
    rom[3] = enc(11, 0, 0, 0, 0);
    apply_reset();
    check_reset_state("t1_reset");
    for (int c = 1; c <= 26; c++) begin
      step(1);
      check($sformatf("t1_c%0d_wb_en", c), 32'(WB_EN), 32'(c == 5 || c == 10 || c == 15));
      check($sformatf("t1_c%0d_halted", c), 32'(HALTED), 32'(c >= 20));
      if (c == 5)  check_wb("t1_ldi_r1", 1, 8'h05);
      if (c == 10) check_wb("t1_ldi_r2", 2, 8'h03);
      if (c == 15) begin
        check_wb("t1_add_r3", 3, 8'h08);
        check("t1_zf", 32'(ZF), 32'd0);
        check("t1_cf", 32'(CF), 32'd0);
      end
    end
    check("t1_pc_frozen", 32'(ROM_ADDR), 32'd3);

    // 2: carry out of ADD and borrow out of SUB
    clear_rom();
    rom[0] = enc(7, 0, 0, 0, 8'hFF);
    rom[1] = enc(7, 1, 0, 0, 8'h01);
    rom[2] = enc(1, 2, 0, 1, 0);
    rom[3] = enc(2, 3, 1, 0, 0);
    rom[4] = enc(11, 0, 0, 0, 0);
    apply_reset();
    step(15);
    check_wb("t2_add", 2, 8'h00);
    check("t2_add_zf", 32'(ZF), 32'd1);
    check("t2_add_cf", 32'(CF), 32'd1);
    step(5);
    check_wb("t2_sub", 3, 8'h02);
    check("t2_sub_zf", 32'(ZF), 32'd0);
    check("t2_sub_cf", 32'(CF), 32'd1);

    // 3: BEQ taken / not taken at PC=4
    clear_rom();
    rom[0] = enc(7, 0, 0, 0, 8'h07);
    rom[1] = enc(7, 1, 0, 0, 8'h09);
    rom[4] = enc(10, 3, 0, 0, 8'h10);
    apply_reset();
    step(20);
    check("t3_pc_before_beq", 32'(ROM_ADDR), 32'd4);
    step(5);
    check("t3_beq_taken_addr", 32'(ROM_ADDR), 32'h10);
    check("t3_beq_taken_wb_en", 32'(WB_EN), 32'd0);
    rom[4] = enc(10, 3, 0, 1, 8'h10);
    apply_reset();
    step(25);
    check("t3_beq_not_taken_addr", 32'(ROM_ADDR), 32'd5);
    check("t3_beq_not_taken_wb_en", 32'(WB_EN), 32'd0);

    // 4: JMP to the top of the address space, unused opcode as NOP, PC wrap
    clear_rom();
    rom[0]     = enc(7, 0, 0, 0, 8'h00);
    rom[1]     = enc(9, 2, 0, 0, 8'hFF);
    rom[8'hFF] = enc(31, 1, 1, 1, 8'hAA);
    apply_reset();
    step(5);
    check_wb("t4_ldi_zero", 0, 8'h00);
    check("t4_ldi_zf", 32'(ZF), 32'd1);
    step(5);
    check("t4_jmp_addr", 32'(ROM_ADDR), 32'hFF);
    check("t4_jmp_wb_en", 32'(WB_EN), 32'd0);
    step(5);
    check("t4_wrap_addr", 32'(ROM_ADDR), 32'h00);
    check("t4_nop31_wb_en", 32'(WB_EN), 32'd0);
    check("t4_nop31_zf_kept", 32'(ZF), 32'd1);
    check("t4_nop31_wb_data_kept", 32'(WB_DATA), 32'h00);

    // 5: one-cycle reset during EXEC of ADD, then reset out of HALT
    clear_rom();
    rom[0] = enc(7, 1, 0, 0, 8'h05);
    rom[1] = enc(1, 2, 1, 1, 0);
    rom[2] = enc(11, 0, 0, 0, 0);
    apply_reset();
    step(5);
    check_wb("t5_ldi", 1, 8'h05);
    step(3);
    RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check_reset_state("t5_mid_reset");
    wb_count = 0;
    for (int c = 1; c <= 4; c++) begin
      step(1);
      if (WB_EN) wb_count++;
    end
    check("t5_no_wb_after_reset", 32'(wb_count), 32'd0);
    step(1);
    check_wb("t5_ldi_again", 1, 8'h05);
    step(5);
    check_wb("t5_add", 2, 8'h0A);
    step(5);
    check("t5_halted", 32'(HALTED), 32'd1);
    step(3);
    check("t5_halt_pc", 32'(ROM_ADDR), 32'd2);
    RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("t5_halt_reset_halted", 32'(HALTED), 32'd0);
    check("t5_halt_reset_addr", 32'(ROM_ADDR), 32'd0);
    step(5);
    check_wb("t5_restart_ldi", 1, 8'h05);

    // 6: rd aliasing a source, then NOT
    clear_rom();
    rom[0] = enc(7, 1, 0, 0, 8'h40);
    rom[1] = enc(1, 1, 1, 1, 0);
    rom[2] = enc(6, 2, 1, 0, 0);
    rom[3] = enc(11, 0, 0, 0, 0);
    apply_reset();
    step(5);
    check_wb("t6_ldi", 1, 8'h40);
    step(5);
    check_wb("t6_add_alias", 1, 8'h80);
    check("t6_add_zf", 32'(ZF), 32'd0);
    check("t6_add_cf", 32'(CF), 32'd0);
    step(5);
    check_wb("t6_not", 2, 8'h7F);
    check("t6_not_zf", 32'(ZF), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_fetch_exec_ctrl.md
Name: cpu_fetch_exec_ctrl

Overview:
Multi-cycle fetch/decode/execute controller for the 19-bit CPU. It sits directly upstream of the 4x8-bit register file.
- Fetches 19-bit instructions from a synchronous program ROM.
- Reads two source registers and computes an 8-bit result.
- Drives the register-file write port (select plus data) once per instruction.
- Also handles jumps, conditional branches and HALT.

Parameters:
PC_W, 8, program counter / ROM address width
INSTR_W, 19, instruction width (fixed by ISA; not to be overridden)
DATA_W, 8, register / ALU data width

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  synchronous, active-high reset
ROM_ADDR  out  PC_W  program ROM address
ROM_DATA  in  19  ROM read data, valid one cycle after ROM_ADDR is presented
RA_SEL  out  2  register-file read index A (rs1)
RB_SEL  out  2  register-file read index B (rs2)
RA_DATA  in  8  register contents at RA_SEL (combinational)
RB_DATA  in  8  register contents at RB_SEL (combinational)
WB_EN  out  1  register write strobe, one cycle per writing instruction
WB_SEL  out  2  destination register index
WB_DATA  out  8  write data
ZF  out  1  zero flag of last ALU op
CF  out  1  carry/borrow of last ADD/SUB
HALTED  out  1  high once HALT executes

Behaviour:
- Instruction format: [18:14] opcode, [13:12] rd, [11:10] rs1, [9:8] rs2, [7:0] imm8.
- Opcodes:
  - 0 NOP
  - 1 ADD rd=rs1+rs2
  - 2 SUB rd=rs1-rs2
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 NOT rd=~rs1
  - 7 LDI rd=imm8
  - 8 MOV rd=rs1
  - 9 JMP pc=imm8
  - 10 BEQ if rs1==rs2 then pc=imm8
  - 11 HALT
  - 12-31 are treated as NOP.
- FSM states: FETCH -> WAIT -> DECODE -> EXEC -> WB -> FETCH; plus HALT. Every instruction takes exactly 5 cycles, including NOP and branches.
- FETCH: ROM_ADDR=PC.
- WAIT: covers the ROM latency.
- DECODE: IR<=ROM_DATA; RA_SEL/RB_SEL are driven from IR fields from the next cycle on.
- EXEC: result, flags and branch decision are registered.
- WB: WB_EN=1 for ALU/LDI/MOV; PC updated (taken target or PC+1).
- Arithmetic:
  - ADD: 9-bit sum; CF=bit8.
  - SUB: CF=1 on borrow (rs1<rs2 unsigned).
  - ZF=(result==0) for opcodes 1-8; flags unchanged otherwise.
  - Logical ops: CF unchanged.
- PC wraps from 2^PC_W-1 to 0 with no fault.
- JMP/BEQ: imm8 truncated or zero-extended to PC_W. BEQ not taken -> PC+1. No write.
- rd equal to rs1/rs2 is legal: sources are sampled in EXEC, before WB.
- HALT: enter HALT at the WB slot. HALTED=1, WB_EN=0, PC frozen; only RST exits.
- WB_SEL/WB_DATA hold their last value when WB_EN=0.
- Reset (valid in any state, mid-instruction included):
  - PC=0, IR=0, state=FETCH.
  - ROM_ADDR=0, WB_EN=0, WB_SEL=0, WB_DATA=0, RA_SEL=0, RB_SEL=0.
  - ZF=0, CF=0, HALTED=0.
  - Any in-flight write is dropped.
- All outputs are registered except RA_SEL/RB_SEL, which decode directly from IR.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants (OP_NOP..OP_HALT)
  - instruction field bit positions
  - state enum (S_FETCH, S_WAIT, S_DECODE, S_EXEC, S_WB, S_HALT)
  - DATA_W
- One sub-module: cpu_alu8. It is purely combinational: op, a, b, imm -> result, carry, zero. The controller owns all sequencing and flag registers.

Test Plan:
1. Reset then program {LDI r1,0x05; LDI r2,0x03; ADD r3,r1,r2; HALT} -> WB pulses (1,0x05), (2,0x03), (3,0x08) at cycles 5, 10, 15 after reset release; ZF=0, CF=0; HALTED=1 at cycle 20; no further WB.
2. LDI r0,0xFF; LDI r1,0x01; ADD r2,r0,r1 -> WB (2,0x00), ZF=1, CF=1. Then SUB r3,r1,r0 -> WB (3,0x02), CF=1 (borrow), ZF=0.
3. BEQ r0,r0,0x10 at PC=4 -> next ROM_ADDR=0x10, no WB_EN. BEQ with unequal regs at PC=4 -> next ROM_ADDR=5.
4. JMP 0xFF followed by NOP at 0xFF (PC_W=8) -> next fetch ROM_ADDR=0x00 (wrap-around); opcode 0x1F behaves as NOP with no WB.
5. Assert RST for one cycle during EXEC of ADD -> no WB_EN that instruction; next cycle ROM_ADDR=0, all outputs at reset values; RST while HALTED -> HALTED=0 and fetch restarts at 0.
6. ADD r1,r1,r1 with r1=0x40 -> WB (1,0x80), ZF=0, CF=0; NOT r2,r1 -> WB (2,0x7F).
